// File: rtl/isp_awb_stat.sv
// -----------------------------------------------------------------------------
// isp_awb_stat : gray-world auto-white-balance estimator.
//
// Sums R/G/B over the valid pixels of each frame. At frame end (rising edge
// of in_vsync) the sums are snapshotted. One restoring divider, used twice,
// then computes gain_r = (sum_g*16)/sum_r and gain_b = (sum_g*16)/sum_b.
// The results are 4.4 fixed-point gains for the downstream isp_wb stage.
//
// Ports
//   pclk, rst_n            pixel clock, asynchronous active-low reset
//   awb_en                 gain update enable, sampled at frame end
//   in_href, in_vsync      line qualifier / vertical blanking
//   in_r, in_g, in_b       pixel data, BITS wide
//   gain_r, gain_g, gain_b 4.4 gains (16 = 1.0), registered
//   gain_valid             one-cycle pulse when new gains are loaded
//   busy                   high while DIV_R / DIV_B / UPDATE run
// -----------------------------------------------------------------------------
module isp_awb_stat #(
    parameter int BITS   = 8,
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 960
) (
    input  logic            pclk,
    input  logic            rst_n,
    input  logic            awb_en,
    input  logic            in_href,
    input  logic            in_vsync,
    input  logic [BITS-1:0] in_r,
    input  logic [BITS-1:0] in_g,
    input  logic [BITS-1:0] in_b,
    output logic [7:0]      gain_r,
    output logic [7:0]      gain_g,
    output logic [7:0]      gain_b,
    output logic            gain_valid,
    output logic            busy
);

    localparam int ACC_W = BITS + $clog2(WIDTH * HEIGHT);
    localparam int N     = ACC_W + 4;
    localparam int CW    = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIV_R  = 2'd1,
        S_DIV_B  = 2'd2,
        S_UPDATE = 2'd3
    } state_t;

    // Saturating accumulate: a long frame pins the sum at all-ones instead of wrapping.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [BITS-1:0]  b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {{(ACC_W + 1 - BITS){1'b0}}, b};
        if (s[ACC_W]) begin
            return {ACC_W{1'b1}};
        end else begin
            return s[ACC_W-1:0];
        end
    endfunction

    // Quotient to 4.4 gain: zero divisor or overflow clamps to 255, zero lifts to 1.
    function automatic logic [7:0] to_gain(input logic [N-1:0] q, input logic div_zero);
        if (div_zero) begin
            return 8'd255;
        end else if (q[N-1:8] != {(N - 8){1'b0}}) begin
            return 8'd255;
        end else if (q[7:0] == 8'd0) begin
            return 8'd1;
        end else begin
            return q[7:0];
        end
    endfunction

    state_t             state_q, state_d;
    logic               vsync_q, vsync_d;
    logic [ACC_W-1:0]   sum_r_q, sum_r_d, sum_g_q, sum_g_d, sum_b_q, sum_b_d;
    logic [ACC_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   snap_r_q, snap_r_d, snap_g_q, snap_g_d, snap_b_q, snap_b_d;
    logic [ACC_W-1:0]   rem_q, rem_d;
    logic [N-1:0]       quo_q, quo_d;
    logic [CW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]         res_r_q, res_r_d, res_b_q, res_b_d;
    logic [7:0]         gain_r_q, gain_r_d, gain_g_q, gain_g_d, gain_b_q, gain_b_d;
    logic               gain_valid_q, gain_valid_d;
    logic               busy_q, busy_d;

    logic               frame_end_s;
    logic               pix_valid_s;
    logic [ACC_W-1:0]   divisor_s;
    logic [ACC_W:0]     rem_sh_s;
    logic [ACC_W:0]     diff_s;
    logic [ACC_W-1:0]   rem_nx_s;
    logic [N-1:0]       quo_nx_s;
    logic               last_s;
    logic               div_zero_s;

    // Frame-end detect, pixel qualification and one restoring-division step.
    always_comb begin
        frame_end_s = in_vsync & ~vsync_q;
        pix_valid_s = in_href & ~in_vsync
                    & (in_r != {BITS{1'b1}})
                    & (in_g != {BITS{1'b1}})
                    & (in_b != {BITS{1'b1}});
        divisor_s   = (state_q == S_DIV_R) ? snap_r_q : snap_b_q;
        div_zero_s  = (divisor_s == {ACC_W{1'b0}});
        // The remainder stays below the divisor, so one extra bit holds the shift.
        rem_sh_s    = {rem_q, quo_q[N-1]};
        diff_s      = rem_sh_s - {1'b0, divisor_s};
        if (rem_sh_s >= {1'b0, divisor_s}) begin
            rem_nx_s = diff_s[ACC_W-1:0];
            quo_nx_s = {quo_q[N-2:0], 1'b1};
        end else begin
            rem_nx_s = rem_sh_s[ACC_W-1:0];
            quo_nx_s = {quo_q[N-2:0], 1'b0};
        end
        last_s = (bit_cnt_q == CW'(N - 1));
    end

    // Next-state logic for accumulators, snapshots, divider FSM and outputs.
    always_comb begin
        state_d      = state_q;
        vsync_d      = in_vsync;
        sum_r_d      = sum_r_q;
        sum_g_d      = sum_g_q;
        sum_b_d      = sum_b_q;
        cnt_d        = cnt_q;
        snap_r_d     = snap_r_q;
        snap_g_d     = snap_g_q;
        snap_b_d     = snap_b_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        bit_cnt_d    = bit_cnt_q;
        res_r_d      = res_r_q;
        res_b_d      = res_b_q;
        gain_r_d     = gain_r_q;
        gain_g_d     = gain_g_q;
        gain_b_d     = gain_b_q;
        gain_valid_d = 1'b0;

        // Accumulators clear on every frame end, busy or not.
        if (frame_end_s) begin
            sum_r_d = {ACC_W{1'b0}};
            sum_g_d = {ACC_W{1'b0}};
            sum_b_d = {ACC_W{1'b0}};
            cnt_d   = {ACC_W{1'b0}};
        end else if (pix_valid_s) begin
            sum_r_d = sat_add(sum_r_q, in_r);
            sum_g_d = sat_add(sum_g_q, in_g);
            sum_b_d = sat_add(sum_b_q, in_b);
            cnt_d   = sat_add(cnt_q, {{(BITS - 1){1'b0}}, 1'b1});
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            S_IDLE: begin
                if (frame_end_s) begin
                    snap_r_d = sum_r_q;
                    snap_g_d = sum_g_q;
                    snap_b_d = sum_b_q;
                    // awb_en and the pixel count are consumed only here, in the
                    // edge cycle, so they are decided on directly rather than held.
                    if (!awb_en) begin
                        res_r_d = 8'd16;
                        res_b_d = 8'd16;
                        state_d = S_UPDATE;
                    end else if (cnt_q != {ACC_W{1'b0}}) begin
                        rem_d     = {ACC_W{1'b0}};
                        quo_d     = {sum_g_q, 4'b0000};
                        bit_cnt_d = {CW{1'b0}};
                        state_d   = S_DIV_R;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DIV_R: begin
                rem_d     = rem_nx_s;
                quo_d     = quo_nx_s;
                bit_cnt_d = bit_cnt_q + CW'(1);
                if (last_s) begin
                    res_r_d   = to_gain(quo_nx_s, div_zero_s);
                    rem_d     = {ACC_W{1'b0}};
                    quo_d     = {snap_g_q, 4'b0000};
                    bit_cnt_d = {CW{1'b0}};
                    state_d   = S_DIV_B;
                end else begin
                    state_d = S_DIV_R;
                end
            end
            S_DIV_B: begin
                rem_d     = rem_nx_s;
                quo_d     = quo_nx_s;
                bit_cnt_d = bit_cnt_q + CW'(1);
                if (last_s) begin
                    res_b_d = to_gain(quo_nx_s, div_zero_s);
                    state_d = S_UPDATE;
                end else begin
                    state_d = S_DIV_B;
                end
            end
            S_UPDATE: begin
                gain_r_d     = res_r_q;
                gain_g_d     = 8'd16;
                gain_b_d     = res_b_q;
                gain_valid_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            vsync_q      <= 1'b0;
            sum_r_q      <= {ACC_W{1'b0}};
            sum_g_q      <= {ACC_W{1'b0}};
            sum_b_q      <= {ACC_W{1'b0}};
            cnt_q        <= {ACC_W{1'b0}};
            snap_r_q     <= {ACC_W{1'b0}};
            snap_g_q     <= {ACC_W{1'b0}};
            snap_b_q     <= {ACC_W{1'b0}};
            rem_q        <= {ACC_W{1'b0}};
            quo_q        <= {N{1'b0}};
            bit_cnt_q    <= {CW{1'b0}};
            res_r_q      <= 8'd16;
            res_b_q      <= 8'd16;
            gain_r_q     <= 8'd16;
            gain_g_q     <= 8'd16;
            gain_b_q     <= 8'd16;
            gain_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync_d;
            sum_r_q      <= sum_r_d;
            sum_g_q      <= sum_g_d;
            sum_b_q      <= sum_b_d;
            cnt_q        <= cnt_d;
            snap_r_q     <= snap_r_d;
            snap_g_q     <= snap_g_d;
            snap_b_q     <= snap_b_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            bit_cnt_q    <= bit_cnt_d;
            res_r_q      <= res_r_d;
            res_b_q      <= res_b_d;
            gain_r_q     <= gain_r_d;
            gain_g_q     <= gain_g_d;
            gain_b_q     <= gain_b_d;
            gain_valid_q <= gain_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign gain_r     = gain_r_q;
    assign gain_g     = gain_g_q;
    assign gain_b     = gain_b_q;
    assign gain_valid = gain_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_isp_awb_stat.sv
// Testbench for isp_awb_stat: directed frames, scoreboard queue of expected
// gains and arrival cycles, and a monitor that pops on every gain_valid.
module tb_isp_awb_stat;

    localparam int BITS   = 8;
    localparam int WIDTH  = 16;
    localparam int HEIGHT = 8;
    localparam int ACC_W  = BITS + $clog2(WIDTH * HEIGHT);
    localparam int N      = ACC_W + 4;

    logic       pclk = 1'b0;
    logic       rst_n;
    logic       awb_en;
    logic       in_href;
    logic       in_vsync;
    logic [7:0] in_r, in_g, in_b;
    logic [7:0] gain_r, gain_g, gain_b;
    logic       gain_valid;
    logic       busy;

    isp_awb_stat #(.BITS(BITS), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .pclk(pclk), .rst_n(rst_n), .awb_en(awb_en),
        .in_href(in_href), .in_vsync(in_vsync),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .gain_r(gain_r), .gain_g(gain_g), .gain_b(gain_b),
        .gain_valid(gain_valid), .busy(busy)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct {
        int r;
        int g;
        int b;
        int t;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   busy_cycles = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: counts busy cycles and checks every gain_valid against the scoreboard.
    always @(negedge pclk) begin
        if (busy) busy_cycles++;
        if (gain_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_gain_valid: got pulse at cycle %0d, required none", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("gain_r", gain_r, mon_e.r);
                chk("gain_g", gain_g, mon_e.g);
                chk("gain_b", gain_b, mon_e.b);
                chk("valid_cycle", cyc, mon_e.t);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic send_pixels(input int r, input int g, input int b, input int n);
        for (int i = 0; i < n; i++) begin
            in_href = 1'b1;
            in_r = 8'(r);
            in_g = 8'(g);
            in_b = 8'(b);
            tick(1);
        end
        in_href = 1'b0;
    endtask

    task automatic send_frame(input int r, input int g, input int b);
        in_vsync = 1'b0;
        tick(2);
        for (int l = 0; l < HEIGHT; l++) begin
            send_pixels(r, g, b, WIDTH);
            tick(2);
        end
    endtask

    // Raise vsync; optionally push the expected gains and their arrival cycle.
    task automatic frame_end(input bit push, input int er, input int eg, input int eb,
                             input int lat);
        in_vsync = 1'b1;
        if (push) sb_q.push_back('{r: er, g: eg, b: eb, t: cyc + lat});
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < limit) begin
            tick(1);
            n++;
        end
        chk(name, sb_q.size(), 0);
        tick(2);
    endtask

    initial begin
        rst_n = 1'b0; awb_en = 1'b1; in_href = 1'b0; in_vsync = 1'b0;
        in_r = 8'd0; in_g = 8'd0; in_b = 8'd0;
        tick(3);
        chk("reset_gain_r", gain_r, 16);
        chk("reset_gain_g", gain_g, 16);
        chk("reset_gain_b", gain_b, 16);
        chk("reset_gain_valid", gain_valid, 0);
        chk("reset_busy", busy, 0);
        rst_n = 1'b1;
        tick(2);

        // Uniform grey frame: unity gains after exactly 2N+2 cycles.
        send_frame(100, 100, 100);
        frame_end(1'b1, 16, 16, 16, 2 * N + 2);
        wait_drain("drain_uniform", 4 * N);

        // R=50 G=100 B=200: 204800/6400=32, 204800/25600=8; busy for 2N+1.
        send_frame(50, 100, 200);
        busy_cycles = 0;
        frame_end(1'b1, 32, 16, 8, 2 * N + 2);
        wait_drain("drain_ratio", 4 * N);
        chk("busy_cycles", busy_cycles, 2 * N + 1);

        // R=5 G=200 B=0: quotient 640 clamps to 255, zero divisor gives 255.
        send_frame(5, 200, 0);
        frame_end(1'b1, 255, 16, 255, 2 * N + 2);
        wait_drain("drain_clamp", 4 * N);

        // All pixels saturated in R: no valid pixel, no update, gains hold.
        send_frame(255, 10, 10);
        frame_end(1'b0, 0, 0, 0, 0);
        tick(2 * N + 10);
        chk("hold_gain_r", gain_r, 255);
        chk("hold_gain_b", gain_b, 255);
        chk("hold_busy", busy, 0);

        // awb_en low at frame end: unity gains two cycles after the edge.
        send_frame(30, 60, 90);
        awb_en = 1'b0;
        frame_end(1'b1, 16, 16, 16, 2);
        wait_drain("drain_disabled", 10);
        awb_en = 1'b1;
        tick(5);

        // Second edge during DIV_B is dropped; its pixels never reach frame 3.
        send_frame(100, 100, 50);
        frame_end(1'b1, 16, 16, 32, 2 * N + 2);
        tick(N + 5);
        in_vsync = 1'b0;
        send_pixels(200, 10, 10, 10);
        frame_end(1'b0, 0, 0, 0, 0);
        wait_drain("drain_busy_edge", 4 * N);
        tick(2 * N);
        // Frame 3: 204800/3200=64, 204800/12800=16.
        send_frame(25, 100, 100);
        frame_end(1'b1, 64, 16, 16, 2 * N + 2);
        wait_drain("drain_frame3", 4 * N);

        // Reset during DIV_R aborts everything; next frame computes cleanly.
        send_frame(100, 100, 100);
        frame_end(1'b0, 0, 0, 0, 0);
        tick(5);
        chk("busy_before_reset", busy, 1);
        rst_n = 1'b0;
        in_vsync = 1'b0;
        #1;
        chk("abort_gain_r", gain_r, 16);
        chk("abort_gain_g", gain_g, 16);
        chk("abort_gain_b", gain_b, 16);
        chk("abort_gain_valid", gain_valid, 0);
        chk("abort_busy", busy, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2 * N + 10);
        // 102400/12800=8, 102400/25600=4.
        send_frame(100, 50, 200);
        frame_end(1'b1, 8, 16, 4, 2 * N + 2);
        wait_drain("drain_after_reset", 4 * N);

        tick(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
